// File: rtl/awgn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : awgn_pkg
// Description : Shared types and sizing for the AWGN core coefficient-memory
//               scheduler. Holds the cos-table geometry, the scheduler FSM
//               state encoding and the port-0 owner encoding used by the
//               round-robin arbiter.
// Contents    : COEFF_DEPTH / COEFF_AW / COEFF_DW  - table geometry
//               sched_state_t                      - scheduler FSM states
//               p0_owner_t                         - port-0 last-winner type
// Revision    : 1.0 - initial release
// ============================================================================
package awgn_pkg;

  localparam int COEFF_DEPTH = 128;
  localparam int COEFF_AW    = 7;
  localparam int COEFF_DW    = 19;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } sched_state_t;

  // Owner of port 0 in the most recent granted cycle. Resetting to
  // OWN_RQ0 makes the updater the preferred side on the first contention.
  typedef enum logic {
    OWN_RQ0 = 1'b0,
    OWN_UPD = 1'b1
  } p0_owner_t;

endpackage : awgn_pkg
`default_nettype wire

// File: rtl/port0_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : port0_rr_arb
// Description : Two-way round-robin arbiter for memory port 0. Requester 0
//               (lookup) and the single-word updater compete; a lone request
//               always wins, and on contention the side that did not win
//               last time is granted.
// Ports       : clk         - clock, rising edge
//               rst         - asynchronous active-high reset
//               rq_req_i    - lookup requester 0 wants port 0
//               upd_req_i   - updater wants port 0
//               rq_gnt_o    - lookup requester 0 owns port 0 this cycle
//               upd_gnt_o   - updater owns port 0 this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module port0_rr_arb
  import awgn_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic rq_req_i,
  input  logic upd_req_i,
  output logic rq_gnt_o,
  output logic upd_gnt_o
);

  p0_owner_t last_q;
  p0_owner_t last_d;
  logic      upd_win;
  logic      rq_win;

  always_comb begin
    // Updater wins when alone, or on contention when requester 0 won last.
    upd_win = upd_req_i & (~rq_req_i | (last_q == OWN_RQ0));
    rq_win  = rq_req_i & ~upd_win;
    last_d  = last_q;
    if (upd_win) begin
      last_d = OWN_UPD;
    end else if (rq_win) begin
      last_d = OWN_RQ0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= OWN_RQ0;
    end else begin
      last_q <= last_d;
    end
  end

  assign rq_gnt_o  = rq_win;
  assign upd_gnt_o = upd_win;

endmodule : port0_rr_arb
`default_nettype wire

// File: rtl/coeff_mem_sched.sv
`default_nettype none
// ============================================================================
// Module      : coeff_mem_sched
// Description : Controller and port scheduler for the dual-port cos
//               coefficient memory. Sequences a full host table load, then
//               shares the two memory ports between two Box-Muller lookup
//               requesters and single-word host updates, with a fixed
//               two-cycle read latency and a write/read hazard guard.
// Ports       : clk, rst                 - clock / async active-high reset
//               load_start               - begin a full load at address 0
//               ld_valid/ld_ready/ld_data - load word handshake
//               load_done, table_ok      - load complete pulse / table valid
//               upd_valid/upd_ready/upd_addr/upd_data - word update
//               rqN_req/rqN_addr/rqN_gnt - lookup request/grant (N=0,1)
//               rqN_rvalid/rqN_rdata     - lookup result (N=0,1)
//               mem_we_N/mem_addr_N/mem_wdata - memory control
//               mem_rdata_N              - memory read data
// Revision    : 1.0 - initial release
// ============================================================================
module coeff_mem_sched
  import awgn_pkg::*;
#(
  parameter int ADDR_WIDTH = COEFF_AW,
  parameter int DATA_WIDTH = COEFF_DW
) (
  input  logic                  clk,
  input  logic                  rst,
  // load / config
  input  logic                  load_start,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic                  load_done,
  output logic                  table_ok,
  // single-word update
  input  logic                  upd_valid,
  output logic                  upd_ready,
  input  logic [ADDR_WIDTH-1:0] upd_addr,
  input  logic [DATA_WIDTH-1:0] upd_data,
  // lookup requesters
  input  logic                  rq0_req,
  input  logic                  rq1_req,
  input  logic [ADDR_WIDTH-1:0] rq0_addr,
  input  logic [ADDR_WIDTH-1:0] rq1_addr,
  output logic                  rq0_gnt,
  output logic                  rq1_gnt,
  output logic                  rq0_rvalid,
  output logic                  rq1_rvalid,
  output logic [DATA_WIDTH-1:0] rq0_rdata,
  output logic [DATA_WIDTH-1:0] rq1_rdata,
  // memory side
  output logic                  mem_we_0,
  output logic                  mem_we_1,
  output logic [ADDR_WIDTH-1:0] mem_addr_0,
  output logic [ADDR_WIDTH-1:0] mem_addr_1,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata_0,
  input  logic [DATA_WIDTH-1:0] mem_rdata_1
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  // --------------------------------------------------------------------------
  // Load sequencer FSM
  // --------------------------------------------------------------------------
  sched_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] ld_cnt_q, ld_cnt_d;
  logic                  last_pend_q, last_pend_d;
  logic                  load_done_q, load_done_d;
  logic                  table_ok_q, table_ok_d;
  logic                  ld_ready_w;

  always_comb begin
    state_d     = state_q;
    ld_cnt_d    = ld_cnt_q;
    last_pend_d = 1'b0;
    load_done_d = 1'b0;
    table_ok_d  = table_ok_q;
    ld_ready_w  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          state_d  = ST_LOAD;
          ld_cnt_d = '0;
        end
      end
      ST_LOAD: begin
        if (load_start) begin
          // Restart wins over any word offered in the same cycle.
          ld_cnt_d = '0;
        end else if (last_pend_q) begin
          // Final word is being committed this cycle; finish the load on
          // the following cycle. ld_ready stays low so the wrapped counter
          // cannot overwrite address 0.
          state_d     = ST_RUN;
          load_done_d = 1'b1;
          table_ok_d  = 1'b1;
        end else begin
          ld_ready_w = 1'b1;
          if (ld_valid) begin
            ld_cnt_d    = ld_cnt_q + ADDR_ONE;
            last_pend_d = &ld_cnt_q;
          end
        end
      end
      ST_RUN: begin
        if (load_start) begin
          state_d    = ST_LOAD;
          ld_cnt_d   = '0;
          table_ok_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ld_cnt_q    <= '0;
      last_pend_q <= 1'b0;
      load_done_q <= 1'b0;
      table_ok_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ld_cnt_q    <= ld_cnt_d;
      last_pend_q <= last_pend_d;
      load_done_q <= load_done_d;
      table_ok_q  <= table_ok_d;
    end
  end

  // --------------------------------------------------------------------------
  // Port scheduling
  // --------------------------------------------------------------------------
  logic run_w;
  logic arb_rq_gnt;
  logic arb_upd_gnt;
  logic ld_hs_w;
  logic wr_en_w;
  logic hazard_w;
  logic rq1_gnt_w;
  logic [ADDR_WIDTH-1:0] wr_addr_w;
  logic [DATA_WIDTH-1:0] wr_data_w;

  assign run_w = (state_q == ST_RUN);

  port0_rr_arb u_port0_arb (
    .clk       (clk),
    .rst       (rst),
    .rq_req_i  (run_w & rq0_req),
    .upd_req_i (run_w & upd_valid),
    .rq_gnt_o  (arb_rq_gnt),
    .upd_gnt_o (arb_upd_gnt)
  );

  // Load writes only happen in LOAD and updates only in RUN, so at most one
  // write source is active in any cycle.
  assign ld_hs_w   = ld_ready_w & ld_valid;
  assign wr_en_w   = ld_hs_w | arb_upd_gnt;
  assign wr_addr_w = ld_hs_w ? ld_cnt_q : upd_addr;
  assign wr_data_w = ld_hs_w ? ld_data : upd_data;

  // The write being registered now commits at the end of the next cycle,
  // exactly when a port-1 read of the same address would sample the old
  // word; hold requester 1 off for one cycle so it observes the new value.
  assign hazard_w  = wr_en_w & (wr_addr_w == rq1_addr);
  assign rq1_gnt_w = run_w & rq1_req & ~hazard_w;

  // --------------------------------------------------------------------------
  // Memory address/write registers and read-valid pipeline
  // --------------------------------------------------------------------------
  logic                  mem_we_0_q;
  logic [ADDR_WIDTH-1:0] mem_addr_0_q, mem_addr_0_d;
  logic [ADDR_WIDTH-1:0] mem_addr_1_q, mem_addr_1_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  rd0_pipe_q, rd1_pipe_q;
  logic                  rq0_rvalid_q, rq1_rvalid_q;

  always_comb begin
    mem_addr_0_d = mem_addr_0_q;
    mem_addr_1_d = mem_addr_1_q;
    mem_wdata_d  = '0;
    if (wr_en_w) begin
      mem_addr_0_d = wr_addr_w;
      mem_wdata_d  = wr_data_w;
    end else if (arb_rq_gnt) begin
      mem_addr_0_d = rq0_addr;
    end
    if (rq1_gnt_w) begin
      mem_addr_1_d = rq1_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we_0_q   <= 1'b0;
      mem_addr_0_q <= '0;
      mem_addr_1_q <= '0;
      mem_wdata_q  <= '0;
      rd0_pipe_q   <= 1'b0;
      rd1_pipe_q   <= 1'b0;
      rq0_rvalid_q <= 1'b0;
      rq1_rvalid_q <= 1'b0;
    end else begin
      mem_we_0_q   <= wr_en_w;
      mem_addr_0_q <= mem_addr_0_d;
      mem_addr_1_q <= mem_addr_1_d;
      mem_wdata_q  <= mem_wdata_d;
      // Stage 1 marks the cycle the address sits on the memory; stage 2 is
      // the cycle the memory presents the word. Granted reads complete even
      // if a reload begins meanwhile.
      rd0_pipe_q   <= arb_rq_gnt;
      rd1_pipe_q   <= rq1_gnt_w;
      rq0_rvalid_q <= rd0_pipe_q;
      rq1_rvalid_q <= rd1_pipe_q;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign ld_ready   = ld_ready_w;
  assign load_done  = load_done_q;
  assign table_ok   = table_ok_q;
  assign upd_ready  = arb_upd_gnt;
  assign rq0_gnt    = arb_rq_gnt;
  assign rq1_gnt    = rq1_gnt_w;
  assign rq0_rvalid = rq0_rvalid_q;
  assign rq1_rvalid = rq1_rvalid_q;
  // The memory output is already registered inside the macro; qualifying it
  // with the registered valid keeps the result at exactly two cycles.
  assign rq0_rdata  = rq0_rvalid_q ? mem_rdata_0 : '0;
  assign rq1_rdata  = rq1_rvalid_q ? mem_rdata_1 : '0;
  assign mem_we_0   = mem_we_0_q;
  assign mem_we_1   = 1'b0;
  assign mem_addr_0 = mem_addr_0_q;
  assign mem_addr_1 = mem_addr_1_q;
  assign mem_wdata  = mem_wdata_q;

endmodule : coeff_mem_sched
`default_nettype wire

// File: tb/tb_coeff_mem_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_coeff_mem_sched
// Description : Directed self-checking bench for coeff_mem_sched. Models the
//               128x19 memory with registered read data (read-before-write)
//               and applies hand-computed vectors: load, dual read, port-0
//               contention, write/read hazard, reload in RUN, reset mid-load.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_coeff_mem_sched;

  localparam int AW = 7;
  localparam int DW = 19;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_start, ld_valid, ld_ready, load_done, table_ok;
  logic [DW-1:0] ld_data;
  logic          upd_valid, upd_ready;
  logic [AW-1:0] upd_addr;
  logic [DW-1:0] upd_data;
  logic          rq0_req, rq1_req, rq0_gnt, rq1_gnt, rq0_rvalid, rq1_rvalid;
  logic [AW-1:0] rq0_addr, rq1_addr;
  logic [DW-1:0] rq0_rdata, rq1_rdata;
  logic          mem_we_0, mem_we_1;
  logic [AW-1:0] mem_addr_0, mem_addr_1;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata_0, mem_rdata_1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  coeff_mem_sched dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_data    (ld_data),
    .load_done  (load_done),
    .table_ok   (table_ok),
    .upd_valid  (upd_valid),
    .upd_ready  (upd_ready),
    .upd_addr   (upd_addr),
    .upd_data   (upd_data),
    .rq0_req    (rq0_req),
    .rq1_req    (rq1_req),
    .rq0_addr   (rq0_addr),
    .rq1_addr   (rq1_addr),
    .rq0_gnt    (rq0_gnt),
    .rq1_gnt    (rq1_gnt),
    .rq0_rvalid (rq0_rvalid),
    .rq1_rvalid (rq1_rvalid),
    .rq0_rdata  (rq0_rdata),
    .rq1_rdata  (rq1_rdata),
    .mem_we_0   (mem_we_0),
    .mem_we_1   (mem_we_1),
    .mem_addr_0 (mem_addr_0),
    .mem_addr_1 (mem_addr_1),
    .mem_wdata  (mem_wdata),
    .mem_rdata_0(mem_rdata_0),
    .mem_rdata_1(mem_rdata_1)
  );

  // Memory model: synchronous read, old data returned on a same-cycle write.
  logic [DW-1:0] mem [128];
  always @(posedge clk) begin
    if (mem_we_0) mem[mem_addr_0] <= mem_wdata;
    mem_rdata_0 <= mem[mem_addr_0];
    mem_rdata_1 <= mem[mem_addr_1];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Streams words k*3 from the current negedge; stops at load_done, after
  // nwords handshakes for a partial load, or at the cycle budget.
  task automatic run_load(input bit do_start, input int nwords, output int nwr,
                          output int werr, output int gap, output int done_lag,
                          output int leak);
    int k, cyc, first_c, last_c, done_c;
    k = 0; cyc = 0; nwr = 0; werr = 0; leak = 0;
    first_c = -1; last_c = -1; done_c = -1;
    if (do_start) begin
      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
    end
    while (cyc < 400 && !(nwords < 128 && k >= nwords)) begin
      if (mem_we_0) begin
        if (nwr == 0) first_c = cyc;
        last_c = cyc;
        if (mem_addr_0 !== nwr[6:0] || mem_wdata !== DW'(nwr * 3)) werr++;
        nwr++;
      end
      if (load_done) begin
        done_c = cyc;
        break;
      end
      ld_valid = (k < nwords);
      ld_data  = DW'(k * 3);
      #1;
      if (ld_valid && ld_ready) k++;
      if (rq0_gnt || rq1_gnt) leak++;
      @(negedge clk);
      cyc++;
    end
    ld_valid = 1'b0;
    gap      = last_c - first_c;
    done_lag = (done_c < 0) ? -1 : done_c - last_c;
  endtask

  int nwr, werr, gap, lag, leak;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    load_start = 0; ld_valid = 0; ld_data = '0;
    upd_valid = 0; upd_addr = '0; upd_data = '0;
    rq0_req = 0; rq1_req = 0; rq0_addr = '0; rq1_addr = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_we0", mem_we_0, 0);
    check_eq("rst_addr0", mem_addr_0, 0);
    check_eq("rst_table_ok", table_ok, 0);
    check_eq("rst_rvalid0", rq0_rvalid, 0);
    rst = 1'b0;
    @(negedge clk);

    // IDLE: nothing is granted
    rq0_req = 1; rq1_req = 1; upd_valid = 1; ld_valid = 1;
    #1;
    check_eq("idle_rq0_gnt", rq0_gnt, 0);
    check_eq("idle_rq1_gnt", rq1_gnt, 0);
    check_eq("idle_upd_ready", upd_ready, 0);
    check_eq("idle_ld_ready", ld_ready, 0);
    rq0_req = 0; rq1_req = 0; upd_valid = 0; ld_valid = 0;
    @(negedge clk);
    check_eq("idle_no_write", mem_we_0, 0);

    // Full load
    run_load(1'b1, 128, nwr, werr, gap, lag, leak);
    check_eq("load_writes", nwr, 128);
    check_eq("load_wr_errs", werr, 0);
    check_eq("load_consecutive", gap, 127);
    check_eq("load_done_lag", lag, 1);
    check_eq("load_table_ok", table_ok, 1);
    check_eq("mem_we_1", mem_we_1, 0);

    // Dual read
    rq0_req = 1; rq0_addr = 7'd5; rq1_req = 1; rq1_addr = 7'd100;
    #1;
    check_eq("dual_gnt0", rq0_gnt, 1);
    check_eq("dual_gnt1", rq1_gnt, 1);
    @(negedge clk);
    rq0_req = 0; rq1_req = 0;
    check_eq("dual_early_rv0", rq0_rvalid, 0);
    check_eq("load_done_pulse", load_done, 0);
    @(negedge clk);
    check_eq("dual_rv0", rq0_rvalid, 1);
    check_eq("dual_rd0", rq0_rdata, 15);
    check_eq("dual_rv1", rq1_rvalid, 1);
    check_eq("dual_rd1", rq1_rdata, 300);
    @(negedge clk);
    check_eq("dual_rv0_single", rq0_rvalid, 0);

    // Contention on port 0: upd, rq0, upd, rq0
    upd_valid = 1; upd_addr = 7'd7; upd_data = 19'h7FFFF;
    rq0_req = 1; rq0_addr = 7'd3;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq($sformatf("cont_upd_%0d", i), upd_ready, (i % 2 == 0) ? 1 : 0);
      check_eq($sformatf("cont_rq0_%0d", i), rq0_gnt, (i % 2 == 1) ? 1 : 0);
      if (i == 3) begin
        check_eq("cont_rv0", rq0_rvalid, 1);
        check_eq("cont_rd0", rq0_rdata, 9);
      end
      @(negedge clk);
    end
    upd_valid = 0; rq0_req = 0;
    @(negedge clk);

    // Read back updated word
    rq0_req = 1; rq0_addr = 7'd7;
    #1;
    check_eq("rd7_gnt", rq0_gnt, 1);
    @(negedge clk);
    rq0_req = 0;
    @(negedge clk);
    check_eq("rd7_rv", rq0_rvalid, 1);
    check_eq("rd7_data", rq0_rdata, 19'h7FFFF);
    @(negedge clk);

    // Hazard: update addr 20 while rq1 asks for addr 20
    upd_valid = 1; upd_addr = 7'd20; upd_data = 19'h12345;
    rq1_req = 1; rq1_addr = 7'd20;
    #1;
    check_eq("haz_upd_ready", upd_ready, 1);
    check_eq("haz_rq1_blocked", rq1_gnt, 0);
    @(negedge clk);
    upd_valid = 0;
    #1;
    check_eq("haz_rq1_retry", rq1_gnt, 1);
    @(negedge clk);
    rq1_req = 0;
    @(negedge clk);
    check_eq("haz_rv1", rq1_rvalid, 1);
    check_eq("haz_rd1", rq1_rdata, 19'h12345);
    @(negedge clk);

    // Reload in RUN with a read in flight
    load_start = 1; rq0_req = 1; rq0_addr = 7'd5;
    #1;
    check_eq("reload_gnt", rq0_gnt, 1);
    @(negedge clk);
    load_start = 0;
    #1;
    check_eq("reload_table_ok", table_ok, 0);
    check_eq("reload_gnt_blocked", rq0_gnt, 0);
    check_eq("reload_ld_ready", ld_ready, 1);
    @(negedge clk);
    check_eq("reload_rv0", rq0_rvalid, 1);
    check_eq("reload_rd0", rq0_rdata, 15);
    run_load(1'b0, 128, nwr, werr, gap, lag, leak);
    check_eq("reload_writes", nwr, 128);
    check_eq("reload_wr_errs", werr, 0);
    check_eq("reload_done_lag", lag, 1);
    check_eq("reload_no_gnt", leak, 0);
    check_eq("reload_table_ok_end", table_ok, 1);
    #1;
    check_eq("reload_gnt_resume", rq0_gnt, 1);
    rq0_req = 0;
    @(negedge clk);
    @(negedge clk);

    // Reset mid-load after 60 words
    run_load(1'b1, 60, nwr, werr, gap, lag, leak);
    check_eq("midload_we_before", mem_we_0, 1);
    rst = 1'b1;
    #1;
    check_eq("midrst_we0", mem_we_0, 0);
    check_eq("midrst_addr0", mem_addr_0, 0);
    check_eq("midrst_wdata", mem_wdata, 0);
    check_eq("midrst_ld_ready", ld_ready, 0);
    check_eq("midrst_table_ok", table_ok, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    load_start = 1;
    @(negedge clk);
    load_start = 0; ld_valid = 1; ld_data = 19'h00ABC;
    @(negedge clk);
    ld_valid = 0;
    check_eq("restart_we0", mem_we_0, 1);
    check_eq("restart_addr0", mem_addr_0, 0);
    check_eq("restart_wdata", mem_wdata, 19'h00ABC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_coeff_mem_sched
`default_nettype wire

// File: doc/coeff_mem_sched.md
# coeff_mem_sched

Controller and port scheduler for the 128x19 dual-port cos-coefficient memory in the AWGN core. It sequences a full table load from the host, then shares the memory's two ports between two Box-Muller lookup requesters (port 0 and port 1) and single-word host updates. It also enforces write/read hazard rules and a fixed read latency. It sits between the host/config interface, the noise datapath lookup stages and `mem_128x19`.

## Interface
- `ADDR_WIDTH`, 7, coefficient address width (table depth 2**ADDR_WIDTH = 128)
- `DATA_WIDTH`, 19, coefficient word width
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `load_start` in 1: pulse; start a full table load at address 0
- `ld_valid` / `ld_ready` in/out 1: load word handshake
- `ld_data` in DATA_WIDTH: load word
- `load_done` out 1: one-cycle pulse after word 127 is written
- `table_ok` out 1: table valid; high from `load_done` until next `load_start` or reset
- `upd_valid` / `upd_ready` in/out 1: single-word update handshake (RUN only)
- `upd_addr` in ADDR_WIDTH, `upd_data` in DATA_WIDTH: update target and value
- `rq0_req`, `rq1_req` in 1: lookup requests
- `rq0_addr`, `rq1_addr` in ADDR_WIDTH: lookup addresses
- `rq0_gnt`, `rq1_gnt` out 1: request accepted this cycle
- `rq0_rvalid`, `rq1_rvalid` out 1: read data valid
- `rq0_rdata`, `rq1_rdata` out DATA_WIDTH: read data
- `mem_we_0`, `mem_we_1` out 1: memory write enables (`mem_we_1` tied 0)
- `mem_addr_0`, `mem_addr_1` out ADDR_WIDTH: memory addresses
- `mem_wdata` out DATA_WIDTH: write data, driven only while `mem_we_0`=1, else 0
- `mem_rdata_0`, `mem_rdata_1` in DATA_WIDTH: memory read data

## Operation
- FSM states:
  - IDLE: reset state. `table_ok`=0, all grants 0.
  - `load_start` → LOAD.
  - LOAD: `ld_ready`=1. Each `ld_valid&ld_ready` writes `ld_data` at `ld_cnt` via port 0, then increments `ld_cnt`. After the write at count 127: `load_done` pulses, `table_ok` goes 1, state → RUN. `ld_cnt` wraps to 0.
  - RUN: serves lookups and updates. `load_start` → LOAD with `ld_cnt`=0 and `table_ok`=0. Reads already granted still complete.
- Grants:
  - Requester grants are 0 outside RUN.
  - `ld_ready` and `upd_ready` are 0 outside LOAD and RUN respectively.
- Port 1: always owned by requester 1, read only.
- Port 0: shared between requester 0 and the updater.
  - If only one of them is active, that one wins.
  - If both contend, a 1-bit last-winner flag alternates ownership. After reset the updater wins first.
- Hazard rule: if port 0 writes address A this cycle and `rq1_req` targets A, `rq1_gnt`=0 for that cycle and requester 1 retries.
- A requester holds `req`/`addr` until it sees `gnt`.
- `load_start` during LOAD restarts the load at 0. `load_start` takes priority over `ld_valid` in the same cycle.

## Timing
- Read latency: grant in cycle N, the address is registered onto `mem_addr_x` in N+1, memory data appears in N+2, and `rqx_rvalid`/`rqx_rdata` are registered in N+2. The latency is fixed at 2. Back-to-back grants give one result per cycle.
- Write: a handshake in cycle N registers `mem_we_0`/`mem_addr_0`/`mem_wdata` for cycle N+1. The memory commits at the end of N+1.
- The hazard comparison uses the write registered for the next cycle against the read being registered in that same cycle.
- Reset values of all outputs: 0. FSM=IDLE, `ld_cnt`=0, last-winner flag=0.
- Reset mid-load or mid-read drops all in-flight work immediately. No `rvalid` is emitted after reset.

## Structure
- Shared package `awgn_pkg`:
  - `COEFF_DEPTH`=128, `COEFF_AW`=7, `COEFF_DW`=19
  - FSM state encoding IDLE/LOAD/RUN
- One sub-module: `port0_rr_arb`, a 2-way round-robin arbiter with a last-winner register, used for port 0.
- The read pipeline and hazard compare stay in the top level.

## Test plan
- Full load: `load_start` then 128 words (`ld_data`=addr*3) with `ld_valid` held high → 128 consecutive `mem_we_0` pulses at addresses 0..127, `load_done` on the cycle after the last write, `table_ok`=1.
- Dual read: in RUN, `rq0_addr`=5 and `rq1_addr`=100 requested together → both granted, both `rvalid` exactly 2 cycles later with data 15 and 300.
- Contention: `upd_valid` (addr 7, data 0x7FFFF) and `rq0_req` both held for 4 cycles → port 0 alternates upd, rq0, upd, rq0. A later `rq0` read of address 7 returns 0x7FFFF.
- Hazard: update to addr 20 in the same cycle `rq1` requests addr 20 → `rq1_gnt`=0 that cycle and 1 the next. Read returns the new value.
- Reset mid-load: assert `rst` after 60 load words → all outputs 0 immediately. A new `load_start` starts writing at address 0.
- Reload in RUN: `load_start` with a grant in flight → the in-flight `rvalid` still arrives, `table_ok` drops, subsequent grants are 0 until `load_done`.
